alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// A three-state FSM (IDLE -> EXEC -> RESP) accepts one request, drives the
// ALU for one cycle, captures the result and holds it until it is consumed.
// Build option: define ALU_ARB_FIXED_PRIO_EN so that requester 0 always wins
// a tie. Without it, ties are resolved round-robin using the last granted id.
module alu_arbiter #(
  parameter int unsigned n = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [3:0]   ctrl0,
  input  logic [3:0]   ctrl1,
  input  logic [n-1:0] a0,
  input  logic [n-1:0] b0,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [n-1:0] alu_w,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] result,
  output logic         zero,
  output logic         rsp_err,
  output logic         busy
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         gnt0_d, gnt1_d;
  logic [n-1:0] alu_a_d, alu_b_d;
  logic [3:0]   alu_ctrl_d;
  logic         rsp_valid_d, rsp_id_d, zero_d, rsp_err_d, busy_d;
  logic [n-1:0] result_d;
  logic         win_c;
  logic         op_ok_c;

  // True when the latched op code is one the ALU actually implements
  always_comb begin
    op_ok_c = 1'b0;
    case (alu_ctrl)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB: op_ok_c = 1'b1;
      default:                                 op_ok_c = 1'b0;
    endcase
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is asking
  always_comb begin
    win_c = ~req0;
  end
`else
  logic last_q;

  // Round-robin: on a tie grant the requester that was not served last
  always_comb begin
    win_c = 1'b1;
    if (req0 && req1) win_c = ~last_q;
    else if (req0)    win_c = 1'b0;
  end

  // Remember the id of every grant; reset value lets requester 0 win first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && (req0 || req1)) begin
      last_q <= win_c;
    end
  end
`endif

  // Next-state and next-output logic; every register holds unless changed
  always_comb begin
    state_d     = state_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_ctrl_d  = alu_ctrl;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_id;
    result_d    = result;
    zero_d      = zero;
    rsp_err_d   = rsp_err;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = EXEC;
          gnt0_d     = ~win_c;
          gnt1_d     = win_c;
          alu_a_d    = win_c ? a1 : a0;
          alu_b_d    = win_c ? b1 : b0;
          alu_ctrl_d = win_c ? ctrl1 : ctrl0;
          rsp_id_d   = win_c;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        if (op_ok_c) begin
          result_d  = alu_w;
          zero_d    = alu_zero;
          rsp_err_d = 1'b0;
        end else begin
          result_d  = '0;
          zero_d    = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_ctrl  <= alu_ctrl_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      result    <= result_d;
      zero      <= zero_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (default round-robin build) with a behavioural ALU.
module tb_alu_arbiter;

  localparam int unsigned N = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [3:0]   ctrl0, ctrl1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_w;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] result;
  logic         zero, rsp_err, busy;

  alu_arbiter #(.n(N)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_w(alu_w), .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .result(result), .zero(zero), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU; unknown op codes produce a nonzero junk value
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_w = alu_a & alu_b;
      4'b0001: alu_w = alu_a | alu_b;
      4'b0010: alu_w = alu_a + alu_b;
      4'b0110: alu_w = alu_a - alu_b;
      4'b0111: alu_w = alu_b;
      default: alu_w = alu_a + alu_b + N'(1);
    endcase
    alu_zero = (alu_w == '0);
  end

  typedef struct {
    bit           r0, r1;
    logic [3:0]   c0;
    logic [N-1:0] x0, y0;
    logic [3:0]   c1;
    logic [N-1:0] x1, y1;
    bit           id;
    logic [N-1:0] res;
    bit           z, e;
  } vec_t;

  typedef struct {
    bit           id;
    logic [N-1:0] res;
    bit           z, e;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input bit id, input logic [N-1:0] res, input bit z, input bit e);
    exp_t x;
    x.id = id; x.res = res; x.z = z; x.e = e;
    sb.push_back(x);
  endtask

  // Pop the oldest expected response and compare it with the DUT response
  task automatic chk_rsp(input string nm);
    exp_t x;
    chk({nm, "_valid"}, N'(rsp_valid), N'(1));
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, N'(1), N'(0));
    end else begin
      x = sb.pop_front();
      chk({nm, "_result"}, result, x.res);
      chk({nm, "_zero"}, N'(zero), N'(x.z));
      chk({nm, "_err"}, N'(rsp_err), N'(x.e));
      chk({nm, "_id"}, N'(rsp_id), N'(x.id));
    end
  endtask

  // Wait (bounded) for a grant pulse; samples 1 time unit after each edge
  task automatic wait_gnt(input string nm, output bit ok, output bit id, output int waited);
    ok = 1'b0; id = 1'b0; waited = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      waited++;
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        id = gnt1;
        chk({nm, "_gnt_onehot"}, N'(gnt0 & gnt1), N'(0));
        break;
      end
    end
    if (!ok) chk({nm, "_gnt_timeout"}, N'(0), N'(1));
  endtask

  task automatic do_row(input string nm, input vec_t v);
    bit ok, id;
    int waited;
    rsp_ready = 1'b1;
    req0 = v.r0; ctrl0 = v.c0; a0 = v.x0; b0 = v.y0;
    req1 = v.r1; ctrl1 = v.c1; a1 = v.x1; b1 = v.y1;
    push_exp(v.id, v.res, v.z, v.e);
    wait_gnt(nm, ok, id, waited);
    if (ok) begin
      chk({nm, "_accept_latency"}, N'(waited), N'(1));
      chk({nm, "_gnt_id"}, N'(id), N'(v.id));
      chk({nm, "_alu_ctrl"}, N'(alu_ctrl), N'(v.id ? v.c1 : v.c0));
      chk({nm, "_alu_a"}, alu_a, v.id ? v.x1 : v.x0);
      chk({nm, "_busy_exec"}, N'(busy), N'(1));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_gnt_one_cycle"}, N'(gnt0 | gnt1), N'(0));
    chk_rsp(nm);
    @(posedge clk); #1;
    chk({nm, "_rsp_done"}, N'(rsp_valid), N'(0));
    chk({nm, "_idle"}, N'(busy), N'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit ok, id;
    int waited;
    exp_t sb_clear[$];

    rst = 1'b1; req0 = 0; req1 = 0; ctrl0 = 0; ctrl1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_ready = 1'b1;

    tbl[0] = '{1, 0, 4'b0010, N'(5), N'(7), 4'b0000, N'(0), N'(0), 0, N'(12), 0, 0};
    tbl[1] = '{0, 1, 4'b0000, N'(0), N'(0), 4'b0110, N'(9), N'(9), 1, N'(0), 1, 0};
    tbl[2] = '{0, 1, 4'b0000, N'(0), N'(0), 4'b0110, N'(0), N'(1), 1, {N{1'b1}}, 0, 0};
    tbl[3] = '{1, 1, 4'b0000, N'(8'hF0), N'(8'h3C), 4'b0001, N'(8'h0F), N'(8'h30), 0, N'(8'h30), 0, 0};
    tbl[4] = '{1, 1, 4'b0010, N'(1), N'(2), 4'b0001, N'(8'h0F), N'(8'h30), 1, N'(8'h3F), 0, 0};
    tbl[5] = '{1, 0, 4'b0101, N'(3), N'(4), 4'b0000, N'(0), N'(0), 0, N'(0), 1, 1};
    tbl[6] = '{1, 0, 4'b0111, N'(1), -N'(5), 4'b0000, N'(0), N'(0), 0, -N'(5), 0, 0};
    tbl[7] = '{0, 1, 4'b0000, N'(0), N'(0), 4'b0010, {1'b0, {(N-1){1'b1}}}, N'(1), 1, {1'b1, {(N-1){1'b0}}}, 0, 0};
    tbl[8] = '{1, 1, 4'b0110, N'(3), N'(5), 4'b0010, N'(1), N'(1), 0, -N'(2), 0, 0};

    // Reset values while reset is held
    #3;
    chk("rst_gnt", N'({gnt0, gnt1}), N'(0));
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_valid", N'(rsp_valid), N'(0));
    chk("rst_result", result, N'(0));
    chk("rst_flags", N'({zero, rsp_err, rsp_id}), N'(0));
    chk("rst_alu", N'({alu_a, alu_b, alu_ctrl} != '0), N'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_row($sformatf("row%0d", i), tbl[i]);
    end

    // Response back-pressure with an error op; a new request must be ignored
    rsp_ready = 1'b0;
    req0 = 1'b1; ctrl0 = 4'b0101; a0 = N'(3); b0 = N'(4);
    push_exp(0, N'(0), 1, 1);
    wait_gnt("stall", ok, id, waited);
    chk("stall_gnt_id", N'(id), N'(0));
    req0 = 1'b0; req1 = 1'b1; ctrl1 = 4'b0010; a1 = N'(1); b1 = N'(1);
    @(posedge clk); #1;
    chk_rsp("stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_valid", N'(rsp_valid), N'(1));
      chk("stall_hold_result", result, N'(0));
      chk("stall_hold_err", N'({zero, rsp_err}), N'(2'b11));
      chk("stall_busy", N'(busy), N'(1));
      chk("stall_no_gnt", N'(gnt0 | gnt1), N'(0));
    end
    req1 = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", N'({rsp_valid, busy}), N'(0));

    // Both requesting continuously after reset: grants alternate 0,1,0,1
    do_reset();
    req0 = 1'b1; ctrl0 = 4'b0010; a0 = N'(10); b0 = N'(1);
    req1 = 1'b1; ctrl1 = 4'b0010; a1 = N'(20); b1 = N'(2);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(0, N'(11), 0, 0);
      else            push_exp(1, N'(22), 0, 0);
      wait_gnt("rr", ok, id, waited);
      chk($sformatf("rr_grant%0d", k), N'(id), N'(k % 2));
      @(posedge clk); #1;
      chk_rsp($sformatf("rr_rsp%0d", k));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Reset during EXEC discards the operation
    sb = sb_clear;
    req0 = 1'b1; ctrl0 = 4'b0010; a0 = N'(1); b0 = N'(1);
    wait_gnt("rst_exec", ok, id, waited);
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_exec_gnt", N'({gnt0, gnt1}), N'(0));
    chk("rst_exec_busy", N'(busy), N'(0));
    chk("rst_exec_alu_a", alu_a, N'(0));
    chk("rst_exec_alu_ctrl", N'(alu_ctrl), N'(0));
    chk("rst_exec_valid", N'(rsp_valid), N'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_exec_no_rsp", N'({rsp_valid, gnt0, gnt1}), N'(0));
    end
    begin
      vec_t v;
      v = '{1, 0, 4'b0111, N'(0), N'(42), 4'b0000, N'(0), N'(0), 0, N'(42), 0, 0};
      do_row("after_rst", v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
